// File: rtl/bn_sqrt_eps.sv
// Iterative fixed-point square root for the batch-norm datapath: out = floor(sqrt(max(in,0)+EPS)) in Q(IL.FL).
// Resolves BPC root bits per clock, MSB first, and carries a request tag from accept to result.
module bn_sqrt_eps #(
  parameter int unsigned IL    = 4,
  parameter int unsigned FL    = 16,
  parameter int unsigned EPS   = 0,
  parameter int unsigned BPC   = 1,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IL+FL-1:0] in,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             input_ready,
  input  logic             output_taken,
  output logic [IL+FL-1:0] out,
  output logic [TAG_W-1:0] tag_out,
  output logic             neg,
  output logic             sat,
  output logic [1:0]       state,
  output logic             done
);

  localparam int unsigned W      = IL + FL;
  localparam int unsigned RW     = W + FL;
  localparam int unsigned N      = RW + (RW % 2);
  localparam int unsigned ITER   = N / 2;
  localparam int unsigned CYCLES = (ITER + BPC - 1) / BPC;
  // Root is widened to a whole number of cycles; extra leading radicand digits are zero.
  localparam int unsigned NI     = CYCLES * BPC;
  localparam int unsigned RAD_W  = 2 * NI;
  localparam int unsigned REM_W  = NI + 2;
  localparam int unsigned CNT_W  = $clog2(CYCLES + 1);

  localparam logic [W:0] MAX_P = {2'b00, {(W-1){1'b1}}};
  localparam logic [W:0] EPS_V = (W+1)'(EPS);

  if (!(BPC == 1 || BPC == 2)) begin : g_bpc_check
    $error("bn_sqrt_eps: BPC must be 1 or 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t             st;
  logic [RAD_W-1:0]   rad_q;
  logic [REM_W-1:0]   rem_q;
  logic [NI-1:0]      root_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [TAG_W-1:0]   tag_q;
  logic               neg_q;
  logic               sat_q;

  logic [W-2:0]       op_c;
  logic [W-2:0]       sum_sat_c;
  logic [W:0]         sum_c;
  logic               neg_c;
  logic               sat_c;
  logic [RAD_W-1:0]   rad_init_c;
  logic               accept_c;

  logic [RAD_W-1:0]   rad_n;
  logic [REM_W-1:0]   rem_n;
  logic [NI-1:0]      root_n;
  logic [REM_W-1:0]   trial_c;

  assign state = st;

  // Operand clamp, epsilon add with saturation, and radicand alignment.
  always_comb begin
    neg_c      = in[W-1];
    op_c       = neg_c ? '0 : in[W-2:0];
    sum_c      = (W+1)'(op_c) + EPS_V;
    sat_c      = (sum_c > MAX_P);
    sum_sat_c  = sat_c ? {(W-1){1'b1}} : sum_c[W-2:0];
    rad_init_c = RAD_W'({sum_sat_c, {FL{1'b0}}});
  end

  assign accept_c = input_ready && ((st == S_IDLE) || ((st == S_DONE) && output_taken));

  // Digit-by-digit root: BPC radicand digit pairs consumed per clock.
  always_comb begin
    rad_n   = rad_q;
    rem_n   = rem_q;
    root_n  = root_q;
    trial_c = '0;
    for (int b = 0; b < int'(BPC); b++) begin
      rem_n   = {rem_n[REM_W-3:0], rad_n[RAD_W-1 -: 2]};
      rad_n   = {rad_n[RAD_W-3:0], 2'b00};
      trial_c = {root_n, 2'b01};
      if (rem_n >= trial_c) begin
        rem_n  = rem_n - trial_c;
        root_n = {root_n[NI-2:0], 1'b1};
      end else begin
        root_n = {root_n[NI-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= S_IDLE;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      tag_q   <= '0;
      neg_q   <= 1'b0;
      sat_q   <= 1'b0;
      out     <= '0;
      tag_out <= '0;
      neg     <= 1'b0;
      sat     <= 1'b0;
      done    <= 1'b0;
    end else if (accept_c) begin
      st     <= S_CALC;
      rad_q  <= rad_init_c;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      tag_q  <= tag_in;
      neg_q  <= neg_c;
      sat_q  <= sat_c;
      done   <= 1'b0;
    end else begin
      case (st)
        S_IDLE: st <= S_IDLE;
        S_CALC: begin
          rad_q  <= rad_n;
          rem_q  <= rem_n;
          root_q <= root_n;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(CYCLES - 1)) begin
            out     <= W'(root_n);
            tag_out <= tag_q;
            neg     <= neg_q;
            sat     <= sat_q;
            done    <= 1'b1;
            st      <= S_DONE;
          end
        end
        S_DONE: begin
          if (output_taken) begin
            st   <= S_IDLE;
            done <= 1'b0;
          end
        end
        default: begin
          st   <= S_IDLE;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bn_sqrt_eps.sv
// Bench for bn_sqrt_eps: four instances (EPS/BPC variants) on shared stimulus, checked against an arithmetic sqrt model.
module tb_bn_sqrt_eps;

  localparam int unsigned IL     = 4;
  localparam int unsigned FL     = 16;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned W      = IL + FL;
  localparam int          NDUT   = 4;
  localparam int          BUDGET = 60;

  function automatic int unsigned eps_of(int i);
    case (i)
      2:       return 16;
      3:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned bpc_of(int i);
    return (i % 2 == 1) ? 2 : 1;
  endfunction

  logic             clk;
  logic             reset;
  logic [W-1:0]     in_v;
  logic [TAG_W-1:0] tag_v;
  logic             input_ready;
  logic             output_taken;

  logic [W-1:0]     out_a  [NDUT];
  logic [TAG_W-1:0] tag_a  [NDUT];
  logic             neg_a  [NDUT];
  logic             sat_a  [NDUT];
  logic [1:0]       st_a   [NDUT];
  logic             done_a [NDUT];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    bn_sqrt_eps #(
      .IL(IL), .FL(FL), .EPS(eps_of(g)), .BPC(bpc_of(g)), .TAG_W(TAG_W)
    ) u_dut (
      .clk(clk), .reset(reset), .in(in_v), .tag_in(tag_v),
      .input_ready(input_ready), .output_taken(output_taken),
      .out(out_a[g]), .tag_out(tag_a[g]), .neg(neg_a[g]), .sat(sat_a[g]),
      .state(st_a[g]), .done(done_a[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic longint isqrt(longint v);
    longint r;
    r = longint'($sqrt(real'(v)));
    while (r * r > v) r--;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Reference: clamp, add epsilon, saturate to max positive, root of the value scaled by 2^FL.
  task automatic model(input int i, input logic [W-1:0] x, output longint r, output bit en, output bit es);
    longint op, s, maxp;
    maxp = (longint'(1) << (W - 1)) - 1;
    en   = x[W-1];
    op   = en ? 0 : longint'(x);
    s    = op + longint'(eps_of(i));
    es   = (s > maxp);
    if (es) s = maxp;
    r = isqrt(s << FL);
  endtask

  function automatic int cycles_of(int i);
    int n, iter;
    n    = int'(W + FL);
    n    = n + (n % 2);
    iter = n / 2;
    return (iter + int'(bpc_of(i)) - 1) / int'(bpc_of(i));
  endfunction

  task automatic send(input logic [W-1:0] x, input logic [TAG_W-1:0] tg);
    in_v = x;
    tag_v = tg;
    input_ready = 1'b1;
    @(posedge clk); #1;
    input_ready = 1'b0;
  endtask

  // Called just after the accept edge: measures latency, then checks the held result.
  task automatic wait_check(input logic [W-1:0] x, input logic [TAG_W-1:0] tg, input int hold);
    int lat [NDUT];
    longint er;
    bit en, es, all;
    for (int i = 0; i < NDUT; i++) lat[i] = -1;
    for (int k = 1; k <= BUDGET; k++) begin
      @(posedge clk); #1;
      all = 1'b1;
      for (int i = 0; i < NDUT; i++) begin
        if (lat[i] < 0 && done_a[i]) lat[i] = k;
        if (lat[i] < 0) all = 1'b0;
      end
      if (all) break;
    end
    repeat (hold) begin @(posedge clk); #1; end
    for (int i = 0; i < NDUT; i++) begin
      model(i, x, er, en, es);
      chk($sformatf("latency[%0d] in=%0d", i, x), lat[i], cycles_of(i));
      chk($sformatf("out[%0d] in=%0d", i, x), out_a[i], er);
      chk($sformatf("neg[%0d] in=%0d", i, x), neg_a[i], en);
      chk($sformatf("sat[%0d] in=%0d", i, x), sat_a[i], es);
      chk($sformatf("tag[%0d] in=%0d", i, x), tag_a[i], tg);
      chk($sformatf("state_done[%0d]", i), st_a[i], 2);
      chk($sformatf("done_hi[%0d]", i), done_a[i], 1);
    end
  endtask

  task automatic drain();
    output_taken = 1'b1;
    input_ready = 1'b0;
    @(posedge clk); #1;
    output_taken = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("state_idle[%0d]", i), st_a[i], 0);
      chk($sformatf("done_lo[%0d]", i), done_a[i], 0);
    end
  endtask

  initial begin
    longint first [NDUT];
    bit en, es;
    logic [W-1:0] x;
    logic [TAG_W-1:0] tg;

    reset = 1'b1;
    in_v = '0;
    tag_v = '0;
    input_ready = 1'b0;
    output_taken = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("rst_state[%0d]", i), st_a[i], 0);
      chk($sformatf("rst_out[%0d]", i), out_a[i], 0);
      chk($sformatf("rst_done[%0d]", i), done_a[i], 0);
      chk($sformatf("rst_flags[%0d]", i), {neg_a[i], sat_a[i], tag_a[i]}, 0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    // input_ready held high throughout; DONE must hold while output_taken stays low.
    in_v = W'(1020);
    tag_v = 4'd1;
    input_ready = 1'b1;
    @(posedge clk); #1;
    wait_check(W'(1020), 4'd1, 5);
    chk("tp_1020_out", out_a[0], 8175);
    drain();

    send(W'(65536), 4'd2);
    wait_check(W'(65536), 4'd2, 0);
    chk("tp_one_bpc1", out_a[0], 65536);
    chk("tp_one_bpc2", out_a[1], 65536);
    drain();

    send(W'(262144), 4'd4);
    wait_check(W'(262144), 4'd4, 0);
    chk("tp_four_bpc1", out_a[0], 131072);
    chk("tp_four_bpc2", out_a[1], 131072);
    drain();

    send(W'(-5), 4'd6);
    wait_check(W'(-5), 4'd6, 0);
    chk("tp_neg_out", out_a[0], 0);
    chk("tp_neg_flag", neg_a[0], 1);
    drain();

    send(W'(0), 4'd8);
    wait_check(W'(0), 4'd8, 0);
    chk("tp_eps16_out", out_a[2], 1024);
    chk("tp_eps16_neg", neg_a[2], 0);
    drain();

    send(W'(524287), 4'd10);
    wait_check(W'(524287), 4'd10, 0);
    chk("tp_sat_flag", sat_a[3], 1);
    chk("tp_sat_out", out_a[3], 185363);
    drain();

    // Back-to-back accept from DONE.
    send(W'(262144), 4'd3);
    wait_check(W'(262144), 4'd3, 0);
    for (int i = 0; i < NDUT; i++) model(i, W'(262144), first[i], en, es);
    in_v = W'(65536);
    tag_v = 4'd5;
    input_ready = 1'b1;
    output_taken = 1'b1;
    @(posedge clk); #1;
    input_ready = 1'b0;
    output_taken = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("b2b_state[%0d]", i), st_a[i], 1);
      chk($sformatf("b2b_done[%0d]", i), done_a[i], 0);
      chk($sformatf("b2b_held_out[%0d]", i), out_a[i], first[i]);
      chk($sformatf("b2b_held_tag[%0d]", i), tag_a[i], 3);
    end
    wait_check(W'(65536), 4'd5, 0);
    chk("b2b_second_out", out_a[0], 65536);
    chk("b2b_second_tag", tag_a[0], 5);
    drain();

    // Reset during CALC cycle 7 aborts everything.
    send(W'(1020), 4'd7);
    repeat (6) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("abort_state[%0d]", i), st_a[i], 0);
      chk($sformatf("abort_out[%0d]", i), out_a[i], 0);
      chk($sformatf("abort_done[%0d]", i), done_a[i], 0);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    send(W'(262144), 4'd9);
    wait_check(W'(262144), 4'd9, 0);
    drain();

    // Randomized operands, half restricted to non-negative values.
    for (int t = 0; t < 20; t++) begin
      if (t % 2 == 0) x = W'($urandom_range(0, (1 << (W - 1)) - 1));
      else            x = W'($urandom);
      tg = TAG_W'($urandom);
      send(x, tg);
      wait_check(x, tg, int'($urandom_range(0, 3)));
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bn_sqrt_eps.md
Name: bn_sqrt_eps

Overview:
- Parametrised, iterative fixed-point square-root unit for the batch-normalisation datapath. Computes out = floor(sqrt(max(in,0) + EPS)) in signed Q(IL.FL) format.
- Successor to the fixed 4.16 single-bit-per-cycle sqrt. Adds:
  - generic IL/FL
  - selectable radix (1 or 2 root bits per cycle)
  - built-in epsilon add with saturation
  - negative-input flag
  - request tag carried through
  - back-to-back accept from DONE
- Sits between the variance accumulator and the normalisation divider.

Parameters:
- IL, 4, integer bits of in/out including sign
- FL, 16, fractional bits of in/out
- EPS, 0, non-negative raw Q(IL.FL) constant added to the radicand before the root
- BPC, 1, root bits resolved per clock (1 or 2; any other value is a compile-time error)
- TAG_W, 4, width of the pass-through request tag

Ports:
- clk, input, 1, clock
- reset, input, 1, synchronous active-high reset
- in, input, IL+FL, signed operand (variance)
- tag_in, input, TAG_W, request tag, captured with in
- input_ready, input, 1, upstream asserts that in/tag_in are valid
- output_taken, input, 1, downstream consumed out; pulse or level
- out, output, IL+FL, signed result, Q(IL.FL)
- tag_out, output, TAG_W, tag of the current result
- neg, output, 1, operand was negative (clamped to 0)
- sat, output, 1, in+EPS overflowed and was saturated
- state, output, 2, 00 IDLE, 01 CALC, 10 DONE (11 unused)
- done, output, 1, high exactly while state==DONE

Behaviour:
- Reset: one clk/reset domain; reset is synchronous and active-high, sampled on the rising edge of clk.
  - state=IDLE; out, tag_out, neg, sat, done and all internal regs = 0.
  - Reset has priority in every state; asserting it mid-CALC aborts the computation, with no output.
- Widths:
  - W=IL+FL.
  - R = ((clamped in + EPS) after saturation) zero-extended and shifted left by FL. R has W+FL bits, padded to an even count N.
  - ITER = N/2 root bits. CYCLES = ceil(ITER/BPC). Defaults: N=36, ITER=18, CYCLES=18 (BPC=1) or 9 (BPC=2).
- Preprocessing, in the accept cycle (registered):
  - If in<0: operand=0, neg=1; else neg=0.
  - sum = operand+EPS. If sum > 2^(W-1)-1: sum = 2^(W-1)-1 and sat=1; else sat=0.
- Algorithm: non-restoring/digit-by-digit integer sqrt of R.
  - Each CALC cycle resolves BPC root bits, MSB first.
  - Exact floor: out^2 <= R < (out+1)^2.
  - Result is always non-negative and fits in W-1 bits.
- IDLE:
  - If input_ready=1, accept on this edge: capture in/tag_in, run preprocessing, clear the iteration counter, go to CALC.
  - Otherwise stay in IDLE.
- CALC:
  - Counter increments each cycle. On the edge completing iteration CYCLES, write out and tag_out, go to DONE.
  - input_ready and output_taken are ignored.
  - done rises exactly CYCLES cycles after the acceptance edge.
- DONE:
  - out, tag_out, neg and sat are held stable.
  - output_taken=1 and input_ready=0: go to IDLE.
  - output_taken=1 and input_ready=1 on the same edge: accept the new operand directly and go to CALC (zero bubble). Outputs keep their old values until the new result is written.
  - output_taken=0: stay in DONE indefinitely, whatever input_ready does.
- Outputs in IDLE/CALC hold the last result (0 after reset). Consumers must qualify them with done.
- Illegal state 11 goes to IDLE on the next edge.

Test Plan:
- Defaults, EPS=0, BPC=1, in=1020, input_ready=1 held, output_taken low for 200 ns.
  - Required: done rises 18 cycles after accept.
  - Required: out=8175, neg=0, sat=0, state=10 held until output_taken, then IDLE.
- in=65536 (1.0) -> out=65536; in=262144 (4.0) -> out=131072. Repeat with BPC=2: same values, done after 9 cycles.
- in=-5, EPS=0 -> out=0, neg=1. With EPS=16 and in=0 -> out=1024, neg=0.
- EPS=1, in=524287 -> sat=1, out=185363.
- Back-to-back:
  - Stimulus: in=262144 with tag 3, then output_taken=1 and input_ready=1 in the same DONE cycle with in=65536, tag 5.
  - Required: state goes straight to CALC; second result is out=65536, tag_out=5.
  - Required: the first result is held while done was high.
- Reset asserted at CALC cycle 7 -> next edge: state=00, out=0, done=0. A new request afterwards completes normally.
